upper_tri_inverse_seq: RTL

Sequential fixed-point inverter for an N×N upper-triangular matrix, the parametrised successor to the team's fixed 3×3 inverter. It accepts the upper triangle as a valid/ready element stream and computes reciprocals of the diagonal with a bit-serial divider. Off-diagonal terms are solved by column-wise back-substitution on one shared MAC, and the inverse triangle is streamed out with back-pressure. It sits downstream of the QR decomposition stage and feeds the solver that multiplies R⁻¹ by Qᵀb.

---
 rtl/upper_tri_inverse_seq.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/upper_tri_inverse_seq.sv
// upper_tri_inverse_seq: fixed-point inverse of an NxN upper-triangular matrix.
// Diagonal reciprocals come from a bit-serial restoring divider; off-diagonal
// terms are solved column by column on one shared MAC, then streamed out.
//
// state | meaning
// LOAD  | accept the upper triangle, row-major
// RSET  | divider setup for diagonal i; zero divisor -> singular, go to OUT
// RDIV  | one quotient bit per cycle, 2*fractionLength+1 cycles
// RFIN  | apply sign, saturate, write X[i][i]
// SMAC  | acc += R[i][k]*X[k][j] for k = i+1..j
// SSCL  | scale acc by -X[i][i], saturate, write X[i][j]
// OUT   | stream the inverse triangle with back-pressure
module upper_tri_inverse_seq #(
  parameter int N              = 3,
  parameter int wordLength     = 16,
  parameter int fractionLength = 12,
  parameter int OUT_WL         = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [wordLength-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [OUT_WL-1:0]     out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  singular_o,
  output logic                  ovf_o
);

  localparam int IW  = $clog2(N);
  localparam int QW  = 2*fractionLength + 1;
  localparam int BW  = $clog2(QW);
  localparam int AW  = wordLength + OUT_WL + 3;
  localparam int PW  = 2*OUT_WL;
  localparam int SW0 = (AW > PW) ? AW : PW;
  localparam int SW  = ((SW0 > QW) ? SW0 : QW) + 2;
  localparam logic [IW-1:0] LAST = IW'(N-1);

  localparam logic [2:0] S_LOAD = 3'd0;
  localparam logic [2:0] S_RSET = 3'd1;
  localparam logic [2:0] S_RDIV = 3'd2;
  localparam logic [2:0] S_RFIN = 3'd3;
  localparam logic [2:0] S_SMAC = 3'd4;
  localparam logic [2:0] S_SSCL = 3'd5;
  localparam logic [2:0] S_OUT  = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [wordLength-1:0] r_q [N][N];
  logic [OUT_WL-1:0]     x_q [N][N];
  logic [IW-1:0]         lrow_q, lcol_q, orow_q, ocol_q, i_q, j_q, k_q;
  logic [BW-1:0]         bcnt_q;
  logic [wordLength-1:0] dvs_q;
  logic [wordLength:0]   rem_q;
  logic [QW-1:0]         quo_q;
  logic signed [AW-1:0]  acc_q;
  logic                  sing_q, ovf_q;

  logic                  in_acc, load_last, out_xfer;
  logic [wordLength-1:0] r_sel, rd_sel, dvs_mag;
  logic [OUT_WL-1:0]     x_sel, xd_sel;
  logic signed [AW-1:0]  r_ext, x_ext, mac_prod, acc_sh;
  logic signed [PW-1:0]  t_ext, d_ext, scl_prod, scl_sh;
  logic signed [SW-1:0]  scl_neg, q_ext, q_sgn;
  logic [OUT_WL:0]       t_res, x_res, q_res;
  logic                  div_bit, rem_ge;
  logic [wordLength:0]   rem_sh, rem_nx;

  // Clamp to OUT_WL bits; the extra MSB of the result flags a clamp.
  function automatic logic [OUT_WL:0] sat_fn(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    hi = {{(SW-OUT_WL+1){1'b0}}, {(OUT_WL-1){1'b1}}};
    lo = {{(SW-OUT_WL+1){1'b1}}, {(OUT_WL-1){1'b0}}};
    if (v > hi)      sat_fn = {1'b1, 1'b0, {(OUT_WL-1){1'b1}}};
    else if (v < lo) sat_fn = {1'b1, 1'b1, {(OUT_WL-1){1'b0}}};
    else             sat_fn = {1'b0, v[OUT_WL-1:0]};
  endfunction

  assign in_ready_o  = (state_q == S_LOAD);
  assign out_valid_o = (state_q == S_OUT);
  assign busy_o      = (state_q != S_LOAD) && (state_q != S_OUT);
  assign singular_o  = sing_q;
  assign ovf_o       = ovf_q;
  assign out_last_o  = out_valid_o && (orow_q == LAST) && (ocol_q == LAST);
  assign out_data_o  = (out_valid_o && !sing_q) ? x_q[orow_q][ocol_q] : '0;
  assign in_acc      = in_valid_i && in_ready_o;
  assign out_xfer    = out_valid_o && out_ready_i;
  assign load_last   = (lrow_q == LAST) && (lcol_q == LAST);

  // Datapath: divider step, reciprocal sign/saturate, MAC product and scaling.
  always_comb begin
    rd_sel   = r_q[i_q][i_q];
    r_sel    = r_q[i_q][k_q];
    x_sel    = x_q[k_q][j_q];
    xd_sel   = x_q[i_q][i_q];
    dvs_mag  = rd_sel[wordLength-1] ? -rd_sel : rd_sel;
    div_bit  = (bcnt_q == BW'(2*fractionLength));
    rem_sh   = (rem_q << 1) | {{wordLength{1'b0}}, div_bit};
    rem_ge   = (rem_sh >= {1'b0, dvs_q});
    rem_nx   = rem_ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    q_ext    = {{(SW-QW){1'b0}}, quo_q};
    q_sgn    = rd_sel[wordLength-1] ? -q_ext : q_ext;
    q_res    = sat_fn(q_sgn);
    r_ext    = {{(AW-wordLength){r_sel[wordLength-1]}}, r_sel};
    x_ext    = {{(AW-OUT_WL){x_sel[OUT_WL-1]}}, x_sel};
    mac_prod = r_ext * x_ext;
    acc_sh   = acc_q >>> fractionLength;
    t_res    = sat_fn({{(SW-AW){acc_sh[AW-1]}}, acc_sh});
    t_ext    = {{(PW-OUT_WL){t_res[OUT_WL-1]}}, t_res[OUT_WL-1:0]};
    d_ext    = {{(PW-OUT_WL){xd_sel[OUT_WL-1]}}, xd_sel};
    scl_prod = t_ext * d_ext;
    scl_sh   = scl_prod >>> fractionLength;
    scl_neg  = -{{(SW-PW){scl_sh[PW-1]}}, scl_sh};
    x_res    = sat_fn(scl_neg);
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: if (in_acc && load_last) state_d = S_RSET;
      S_RSET: state_d = (rd_sel == '0) ? S_OUT : S_RDIV;
      S_RDIV: if (bcnt_q == '0) state_d = S_RFIN;
      S_RFIN: state_d = (i_q == LAST) ? S_SMAC : S_RSET;
      S_SMAC: if (k_q == j_q) state_d = S_SSCL;
      S_SSCL: state_d = ((i_q == '0) && (j_q == LAST)) ? S_OUT : S_SMAC;
      S_OUT:  if (out_xfer && out_last_o) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // State, counters, matrix storage and flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_LOAD;
      lrow_q  <= '0;
      lcol_q  <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      bcnt_q  <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      acc_q   <= '0;
      sing_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int a = 0; a < N; a++) begin
        for (int b = 0; b < N; b++) begin
          r_q[a][b] <= '0;
          x_q[a][b] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        S_LOAD: if (in_acc) begin
          r_q[lrow_q][lcol_q] <= in_data_i;
          if ((lrow_q == '0) && (lcol_q == '0)) begin
            sing_q <= 1'b0;
            ovf_q  <= 1'b0;
          end
          if (load_last) begin
            lrow_q <= '0;
            lcol_q <= '0;
            i_q    <= '0;
          end else if (lcol_q == LAST) begin
            lrow_q <= lrow_q + IW'(1);
            lcol_q <= lrow_q + IW'(1);
          end else begin
            lcol_q <= lcol_q + IW'(1);
          end
        end
        S_RSET: begin
          if (rd_sel == '0) begin
            sing_q <= 1'b1;
          end else begin
            dvs_q  <= dvs_mag;
            rem_q  <= '0;
            quo_q  <= '0;
            bcnt_q <= BW'(2*fractionLength);
          end
        end
        S_RDIV: begin
          rem_q <= rem_nx;
          quo_q <= (quo_q << 1) | {{(QW-1){1'b0}}, rem_ge};
          if (bcnt_q != '0) bcnt_q <= bcnt_q - BW'(1);
        end
        S_RFIN: begin
          x_q[i_q][i_q] <= q_res[OUT_WL-1:0];
          if (q_res[OUT_WL]) ovf_q <= 1'b1;
          if (i_q == LAST) begin
            i_q <= '0;
            j_q <= IW'(1);
            k_q <= IW'(1);
          end else begin
            i_q <= i_q + IW'(1);
          end
        end
        S_SMAC: begin
          acc_q <= (k_q == i_q + IW'(1)) ? mac_prod : acc_q + mac_prod;
          if (k_q != j_q) k_q <= k_q + IW'(1);
        end
        S_SSCL: begin
          x_q[i_q][j_q] <= x_res[OUT_WL-1:0];
          if (t_res[OUT_WL] || x_res[OUT_WL]) ovf_q <= 1'b1;
          if (i_q == '0) begin
            if (j_q != LAST) begin
              j_q <= j_q + IW'(1);
              i_q <= j_q;
              k_q <= j_q + IW'(1);
            end
          end else begin
            i_q <= i_q - IW'(1);
            k_q <= i_q;
          end
        end
        S_OUT: if (out_xfer) begin
          if (out_last_o) begin
            orow_q <= '0;
            ocol_q <= '0;
          end else if (ocol_q == LAST) begin
            orow_q <= orow_q + IW'(1);
            ocol_q <= orow_q + IW'(1);
          end else begin
            ocol_q <= ocol_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
